count_direction_decoder: RTL and testbench

Receive-side companion to the up/down counter. It samples a counter's output bus, recovers the counting direction, and indicates when that direction is stable (lock). It also flags wrap-around events and illegal steps. It sits downstream of the counter as a monitor/decoder, so other logic never needs the counter's mode input.

---
 rtl/count_direction_decoder.sv | 154 +++++++++++++++
 tb/tb_count_direction_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/count_direction_decoder.sv
// count_direction_decoder
//
// Monitors the output bus of an up/down counter and recovers the counting
// direction from successive samples, so downstream logic never needs the
// counter's own mode input.
//
// Each accepted sample is classified against the previous one as an UP
// step (+1), a DOWN step (-1), a HOLD (same value) or a JUMP (anything
// else, illegal). LOCK_COUNT consecutive steps in the same direction
// establish lock. Once locked, a reversal flips dir and pulses dir_change.
// A JUMP drops lock and restarts acquisition. Wrap-around steps are legal
// and are flagged separately.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high (dominates in_valid)
//   in_valid   in   count_in is sampled this cycle
//   count_in   in   observed counter value [WIDTH]
//   dir        out  recovered direction, 1 = up, 0 = down (valid while locked)
//   locked     out  direction stable
//   dir_change out  one-cycle pulse: direction reversed while locked
//   wrap_up    out  one-cycle pulse: up step from all-ones to 0
//   wrap_dn    out  one-cycle pulse: down step from 0 to all-ones
//   step_err   out  one-cycle pulse: illegal step observed
//   err_count  out  saturating count of step_err events [ERR_CNT_W]
//
// All outputs are registered: the response to a sample appears the cycle
// after it is accepted.

module count_direction_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 dir,
  output logic                 locked,
  output logic                 dir_change,
  output logic                 wrap_up,
  output logic                 wrap_dn,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam int               RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;
  logic             cand;

  logic [WIDTH-1:0] delta_p0;
  logic             step_up_p0;
  logic             step_dn_p0;
  logic             step_jump_p0;
  logic             acq_match_p0;
  logic [RUN_W-1:0] run_inc_p0;

  // Counter that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Stage 0: classify the incoming sample against prev (modulo 2^WIDTH).
  always_comb begin
    delta_p0     = count_in - prev;
    step_up_p0   = (delta_p0 == RUN_W'(0) + WIDTH'(1));
    step_dn_p0   = (delta_p0 == ALL_ONES);
    step_jump_p0 = !(step_up_p0 || step_dn_p0 || (delta_p0 == '0));
    // A run only continues if one is already in progress in the same
    // direction; otherwise this step starts a fresh run of length one.
    acq_match_p0 = (run != '0) && (cand == step_up_p0);
    run_inc_p0   = acq_match_p0 ? run + 1'b1 : RUN_ONE;
  end

  // Stage 1: state update and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      prev       <= '0;
      run        <= '0;
      cand       <= 1'b0;
      dir        <= 1'b0;
      locked     <= 1'b0;
      dir_change <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      dir_change <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      step_err   <= 1'b0;
      if (in_valid) begin
        prev <= count_in;
        // The very first sample has no predecessor, so wraps are only
        // meaningful once a prev value has been captured.
        if (state != S_IDLE) begin
          wrap_up <= step_up_p0 && (prev == ALL_ONES);
          wrap_dn <= step_dn_p0 && (prev == '0);
        end
        case (state)
          S_IDLE: begin
            state <= S_ACQ;
            run   <= '0;
          end
          S_ACQ: begin
            if (step_jump_p0) begin
              step_err  <= 1'b1;
              err_count <= sat_inc(err_count);
              run       <= '0;
            end else if (step_up_p0 || step_dn_p0) begin
              run  <= run_inc_p0;
              cand <= step_up_p0;
              if (run_inc_p0 == RUN_LOCK) begin
                state  <= S_LOCK;
                dir    <= step_up_p0;
                locked <= 1'b1;
              end
            end
          end
          S_LOCK: begin
            if (step_jump_p0) begin
              step_err  <= 1'b1;
              err_count <= sat_inc(err_count);
              locked    <= 1'b0;
              run       <= '0;
              state     <= S_ACQ;
            end else if ((step_up_p0 || step_dn_p0) && (step_up_p0 != dir)) begin
              dir        <= step_up_p0;
              dir_change <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            run   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_direction_decoder.sv
module tb_count_direction_decoder;

  localparam int WIDTH      = 4;
  localparam int LOCK_COUNT = 3;
  localparam int ERR_CNT_W  = 8;
  localparam int M          = 1 << WIDTH;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [WIDTH-1:0]     count_in;
  logic                 dir;
  logic                 locked;
  logic                 dir_change;
  logic                 wrap_up;
  logic                 wrap_dn;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_count;

  count_direction_decoder #(
    .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
    .dir(dir), .locked(locked), .dir_change(dir_change),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .step_err(step_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dir;
    bit locked;
    bit dir_change;
    bit wrap_up;
    bit wrap_dn;
    bit step_err;
    int err_count;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: tracks the history of legal step directions since
  // acquisition (re)started; lock is reached when the most recent
  // LOCK_COUNT steps all agree.
  bit m_started;
  int m_prev;
  bit hist[$];
  bit m_locked;
  bit m_dir;
  int m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input int c_in);
    exp_t e;
    int c;
    int d;
    bit up, dn, jump, all_eq;
    c = c_in % M;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    count_in = WIDTH'(c);
    e = '{default: 0};
    if (r) begin
      m_started = 0;
      hist.delete();
      m_locked = 0;
      m_dir    = 0;
      m_err    = 0;
      m_prev   = 0;
    end else if (v) begin
      if (!m_started) begin
        m_started = 1;
        hist.delete();
      end else begin
        d    = (c - m_prev + M) % M;
        up   = (d == 1);
        dn   = (d == M - 1);
        jump = !(up || dn || d == 0);
        e.wrap_up = up && (m_prev == M - 1);
        e.wrap_dn = dn && (m_prev == 0);
        if (jump) begin
          e.step_err = 1;
          if (m_err < ERR_MAX) m_err++;
          m_locked = 0;
          hist.delete();
        end else if (up || dn) begin
          if (m_locked) begin
            if (up != m_dir) begin
              m_dir = up;
              e.dir_change = 1;
            end
          end else begin
            hist.push_back(up);
            if (hist.size() >= LOCK_COUNT) begin
              all_eq = 1;
              for (int i = 1; i <= LOCK_COUNT; i++)
                if (hist[hist.size() - i] != up) all_eq = 0;
              if (all_eq) begin
                m_locked = 1;
                m_dir    = up;
              end
            end
          end
        end
      end
      m_prev = c;
    end
    e.dir       = m_dir;
    e.locked    = m_locked;
    e.err_count = m_err;
    sb.push_back(e);
  endtask

  task automatic feed(input int c);
    drive(1'b0, 1'b1, c);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, int'($urandom_range(0, M - 1)));
  endtask

  // Monitor: every cycle the DUT presents a response one cycle after the
  // stimulus; compare it against the oldest outstanding expectation.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dir",        32'(dir),        32'(e.dir));
      chk("locked",     32'(locked),     32'(e.locked));
      chk("dir_change", 32'(dir_change), 32'(e.dir_change));
      chk("wrap_up",    32'(wrap_up),    32'(e.wrap_up));
      chk("wrap_dn",    32'(wrap_dn),    32'(e.wrap_dn));
      chk("step_err",   32'(step_err),   32'(e.step_err));
      chk("err_count",  32'(err_count),  32'(e.err_count));
    end
  end

  initial begin
    int cur;
    bit bias_up;
    int r;
    rst      = 1'b1;
    in_valid = 1'b0;
    count_in = '0;

    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0);

    // Acquire upward lock from reset.
    for (int i = 0; i <= 4; i++) feed(i);
    // Count up through the top of the range: one wrap_up.
    for (int i = 5; i <= 17; i++) feed(i % M);
    for (int i = 2; i <= 6; i++) feed(i);
    // Reverse while locked, then wrap downward.
    for (int i = 5; i >= -1; i--) feed((i + M) % M);
    // Descend to 5, jump to 9, reacquire upward.
    for (int i = 14; i >= 5; i--) feed(i);
    feed(9);
    for (int i = 10; i <= 12; i++) feed(i);
    // Climb to 7, holds with gaps, then step to 8.
    for (int i = 13; i <= 23; i++) feed(i % M);
    feed(7); gap(); feed(7); gap(); feed(7); gap();
    feed(8);
    // Saturate the error counter.
    for (int k = 0; k < 256; k++) feed((k % 2 == 0) ? 0 : 8);
    for (int i = 9; i <= 11; i++) feed(i);
    // Reset dominates a valid sample, then reacquire.
    drive(1'b1, 1'b1, 8);
    for (int i = 8; i <= 11; i++) feed(i);

    // Randomized walk with occasional jumps, holds, gaps and resets.
    cur = 11;
    bias_up = 1;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        drive(1'b1, 1'($urandom_range(0, 1)), cur);
      end else if (r < 10) begin
        gap();
      end else if (r < 15) begin
        cur = (cur + int'($urandom_range(2, M - 2))) % M;
        feed(cur);
      end else if (r < 25) begin
        feed(cur);
      end else begin
        if ($urandom_range(0, 99) < 6) bias_up = !bias_up;
        cur = bias_up ? (cur + 1) % M : (cur + M - 1) % M;
        feed(cur);
      end
    end

    @(posedge clk);
    #2;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
